// File: rtl/rise_counter_if.sv
// rise_counter_if
//   Signal bundle between the jump controller and its user.
//   master : drives enable, jump, y_start; observes the rise outputs.
//   slave  : the rise_counter side; drives y_out, move, rising, apex, period.
//   Signals:
//     enable  - global run/pause
//     jump    - launch request (honoured only while idle)
//     y_start - launch y coordinate
//     y_out   - current y coordinate
//     move    - one-cycle pulse when y_out steps during a rise
//     rising  - high while a rise is in progress
//     apex    - one-cycle pulse when the rise ends
//     period  - current tick period in clk cycles
interface rise_counter_if;
    logic        enable;
    logic        jump;
    logic [7:0]  y_start;
    logic [7:0]  y_out;
    logic        move;
    logic        rising;
    logic        apex;
    logic [25:0] period;

    modport master (
        output enable, jump, y_start,
        input  y_out, move, rising, apex, period
    );

    modport slave (
        input  enable, jump, y_start,
        output y_out, move, rising, apex, period
    );
endinterface

// File: rtl/rise_counter.sv
// rise_counter
//   Upward-motion (jump) controller for the player sprite. A jump request in
//   IDLE starts a rise: y decreases by Y_STEP every time the tick counter
//   reaches the current period, and each step lengthens the period by
//   PERIOD_STEP so the sprite decelerates. The rise ends (one-cycle apex) when
//   the period reaches APEX_PERIOD or the ceiling Y_MIN is hit.
//   Ports:
//     clk    - clock
//     resetn - synchronous, active-low reset
//     bus    - rise_counter_if.slave (enable, jump, y_start in;
//              y_out, move, rising, apex, period out; all outputs registered)
module rise_counter #(
    parameter logic [25:0] START_PERIOD = 26'd5000000,
    parameter logic [25:0] PERIOD_STEP  = 26'd300000,
    parameter logic [25:0] APEX_PERIOD  = 26'd25000000,
    parameter logic [2:0]  Y_STEP       = 3'd1,
    parameter logic [7:0]  Y_MIN        = 8'd0
) (
    input  logic           clk,
    input  logic           resetn,
    rise_counter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_APEX = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [25:0] counter;
    logic        step;
    logic        ceil_hit;
    logic [26:0] period_sum;
    logic [25:0] period_sat;

    always_comb begin
        step       = (state == S_RISE) && bus.enable && (counter >= bus.period);
        // 9-bit compare so Y_MIN+Y_STEP cannot wrap
        ceil_hit   = ({1'b0, bus.y_out} < ({1'b0, Y_MIN} + {6'd0, Y_STEP}));
        // 27-bit sum so a large step saturates instead of wrapping
        period_sum = {1'b0, bus.period} + {1'b0, PERIOD_STEP};
        period_sat = (period_sum >= {1'b0, APEX_PERIOD}) ? APEX_PERIOD : period_sum[25:0];

        state_nxt = state;
        case (state)
            S_IDLE: if (bus.enable && bus.jump) state_nxt = S_RISE;
            S_RISE: if (step && (ceil_hit || (period_sat >= APEX_PERIOD))) state_nxt = S_APEX;
            S_APEX: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            counter    <= '0;
            bus.y_out  <= bus.y_start;
            bus.period <= START_PERIOD;
            bus.move   <= 1'b0;
            bus.apex   <= 1'b0;
            bus.rising <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus.move   <= step;
            bus.apex   <= (state_nxt == S_APEX);
            bus.rising <= (state_nxt == S_RISE);
            case (state)
                S_RISE: begin
                    if (step) begin
                        counter    <= '0;
                        bus.period <= period_sat;
                        bus.y_out  <= ceil_hit ? Y_MIN : (bus.y_out - {5'd0, Y_STEP});
                    end else if (bus.enable) begin
                        counter <= counter + 26'd1;
                    end
                end
                // y_out is stable for the whole APEX cycle; the reload on the
                // APEX->IDLE edge makes the first IDLE cycle already show y_start.
                default: begin
                    counter    <= '0;
                    bus.y_out  <= bus.y_start;
                    bus.period <= START_PERIOD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rise_counter.sv
// tb_rise_counter
//   Directed bench for rise_counter: a small-parameter instance covering basic
//   rise, pause, jump-while-paused, re-trigger, reset mid-rise and ceiling, plus
//   a second instance whose period sum overflows 26 bits to exercise saturation.
module tb_rise_counter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rise_counter_if bus ();
    rise_counter_if bus_s ();

    rise_counter #(
        .START_PERIOD(26'd4),
        .PERIOD_STEP (26'd2),
        .APEX_PERIOD (26'd10),
        .Y_STEP      (3'd1),
        .Y_MIN       (8'd0)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    rise_counter #(
        .START_PERIOD(26'd2),
        .PERIOD_STEP (26'h3FFFFFF),
        .APEX_PERIOD (26'h3FFFFFF),
        .Y_STEP      (3'd1),
        .Y_MIN       (8'd0)
    ) dut_sat (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch from an IDLE cycle N and check every cycle N+1 .. N+m3+2.
    // Moves expected at m1, m2, m3 (apex at m3); enable low for p_len cycles from p_at.
    task automatic rise_run(input string nm, input logic [7:0] ys,
                            input int m1, input int m2, input int m3,
                            input int p_at, input int p_len, input logic hold);
        logic [7:0]  y_e;
        logic [25:0] p_e;
        logic        mv;
        bus.y_start = ys;
        bus.jump    = 1'b1;
        tick();
        if (!hold) bus.jump = 1'b0;
        y_e = ys;
        p_e = 26'd4;
        for (int k = 1; k <= m3 + 1; k++) begin
            bus.enable = !(k >= p_at && k < p_at + p_len);
            mv = (k == m1) || (k == m2) || (k == m3);
            if (mv) begin
                y_e = y_e - 8'd1;
                p_e = p_e + 26'd2;
            end
            if (k == m3 + 1) begin
                y_e = ys;
                p_e = 26'd4;
            end
            check($sformatf("%s.move@%0d", nm, k),   bus.move,   mv);
            check($sformatf("%s.apex@%0d", nm, k),   bus.apex,   (k == m3));
            check($sformatf("%s.rising@%0d", nm, k), bus.rising, (k < m3));
            check($sformatf("%s.y_out@%0d", nm, k),  bus.y_out,  y_e);
            check($sformatf("%s.period@%0d", nm, k), bus.period, p_e);
            tick();
        end
        bus.enable = 1'b1;
        check($sformatf("%s.rising@%0d", nm, m3 + 2), bus.rising, hold);
        bus.jump = 1'b0;
    endtask

    initial begin
        logic seen;
        resetn        = 1'b0;
        bus.enable    = 1'b1;
        bus.jump      = 1'b0;
        bus.y_start   = 8'd100;
        bus_s.enable  = 1'b1;
        bus_s.jump    = 1'b0;
        bus_s.y_start = 8'd50;
        tick();
        tick();
        check("rst.y_out",   bus.y_out,    100);
        check("rst.period",  bus.period,   4);
        check("rst.rising",  bus.rising,   0);
        check("rst.apex",    bus.apex,     0);
        check("rst.move",    bus.move,     0);
        check("rst.sat_per", bus_s.period, 2);
        resetn = 1'b1;
        tick();

        // Basic rise
        rise_run("basic", 8'd100, 6, 13, 22, 0, 0, 1'b0);

        // Pause for 5 cycles from N+3 shifts every move by 5
        rise_run("pause", 8'd100, 11, 18, 27, 3, 5, 1'b0);

        // Jump while paused in IDLE is not taken
        bus.enable = 1'b0;
        bus.jump   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("paused_jump.rising@%0d", k), bus.rising, 0);
        end
        bus.jump   = 1'b0;
        bus.enable = 1'b1;
        tick();
        check("paused_jump.after", bus.rising, 0);

        // Jump held high: same sequence, new rise at N+24
        rise_run("hold", 8'd100, 6, 13, 22, 0, 0, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Reset at N+10 abandons the rise without apex
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        check("midrst.y_before", bus.y_out, 99);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst.y_out",  bus.y_out,  100);
        check("midrst.period", bus.period, 4);
        check("midrst.rising", bus.rising, 0);
        check("midrst.apex",   bus.apex,   0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.apex || bus.rising) seen = 1'b1;
        end
        check("midrst.no_apex", seen, 0);
        rise_run("restart", 8'd100, 6, 13, 22, 0, 0, 1'b0);

        // Ceiling: launch at y=0, first step ends the rise
        bus.y_start = 8'd0;
        tick();
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("ceil.move@%0d", k), bus.move, (k == 6));
            check($sformatf("ceil.apex@%0d", k), bus.apex, (k == 6));
            check($sformatf("ceil.y@%0d", k),    bus.y_out, 0);
            if (k < 6) tick();
        end
        check("ceil.period", bus.period, 6);
        check("ceil.rising", bus.rising, 0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.move || bus.apex || bus.rising) seen = 1'b1;
        end
        check("ceil.no_second", seen, 0);

        // Saturation: 2 + 26'h3FFFFFF overflows 26 bits, must clamp
        bus_s.jump = 1'b1;
        tick();
        bus_s.jump = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("sat.move@%0d", k), bus_s.move, (k == 4));
            check($sformatf("sat.apex@%0d", k), bus_s.apex, (k == 4));
            check($sformatf("sat.period@%0d", k), bus_s.period,
                  (k == 4) ? 32'h3FFFFFF : 32'd2);
            check($sformatf("sat.y@%0d", k), bus_s.y_out, (k == 4) ? 32'd49 : 32'd50);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
